// File: rtl/maxnet_controller.sv
// MAXNET competition controller: sequences input capture, ProcessingUnit
// latency waits and ReLU feedback updates until a single winner or timeout.
module maxnet_controller #(
    parameter int PU_LATENCY = 2,
    parameter int MAX_ITER   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dp_done,
    input  logic       ack,
    output logic       ldX,
    output logic       ldTmp,
    output logic       selTmp,
    output logic       ready,
    output logic       busy,
    output logic       result_valid,
    output logic       timeout,
    output logic [7:0] iter_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_PU,
        UPDATE,
        CHECK,
        FINISH,
        ERROR
    } state_t;

    localparam logic [3:0] LAT_LAST   = 4'(PU_LATENCY - 1);
    localparam logic [7:0] ITER_LIMIT = 8'(MAX_ITER);

    state_t     state;
    state_t     state_n;
    logic [3:0] lat_cnt;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) state_n = LOAD;
            end
            LOAD: begin
                state_n = WAIT_PU;
            end
            WAIT_PU: begin
                if (lat_cnt == LAT_LAST) state_n = UPDATE;
            end
            UPDATE: begin
                state_n = CHECK;
            end
            CHECK: begin
                if (dp_done)
                    state_n = FINISH;
                else if (iter_count == ITER_LIMIT)
                    state_n = ERROR;
                else
                    state_n = WAIT_PU;
            end
            FINISH, ERROR: begin
                if (ack) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lat_cnt      <= 4'd0;
            iter_count   <= 8'd0;
            ldX          <= 1'b0;
            ldTmp        <= 1'b0;
            selTmp       <= 1'b0;
            ready        <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state <= state_n;

            // Entry into WAIT_PU always comes from another state.
            if (state == WAIT_PU)
                lat_cnt <= lat_cnt + 4'd1;
            else
                lat_cnt <= 4'd0;

            if (state == IDLE && start)
                iter_count <= 8'd0;
            else if (state == UPDATE && iter_count != 8'hFF)
                iter_count <= iter_count + 8'd1;

            ldX          <= (state_n == LOAD);
            ldTmp        <= (state_n == LOAD) || (state_n == UPDATE);
            selTmp       <= (state_n == UPDATE);
            ready        <= (state_n == IDLE);
            busy         <= (state_n == LOAD) || (state_n == WAIT_PU) ||
                            (state_n == UPDATE) || (state_n == CHECK);
            result_valid <= (state_n == FINISH);
            timeout      <= (state_n == ERROR);
        end
    end

endmodule

// File: tb/tb_maxnet_controller.sv
// Randomised scoreboard bench for maxnet_controller against a run-level
// model: each run's outcome, timing and pulse counts follow from its length.
module tb_maxnet_controller;

    localparam int L  = 2;
    localparam int MI = 4;
    localparam int P  = L + 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic       dp_done;
    logic       ack;
    logic       ldX;
    logic       ldTmp;
    logic       selTmp;
    logic       ready;
    logic       busy;
    logic       result_valid;
    logic       timeout;
    logic [7:0] iter_count;

    maxnet_controller #(
        .PU_LATENCY(L),
        .MAX_ITER  (MI)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dp_done     (dp_done),
        .ack         (ack),
        .ldX         (ldX),
        .ldTmp       (ldTmp),
        .selTmp      (selTmp),
        .ready       (ready),
        .busy        (busy),
        .result_valid(result_valid),
        .timeout     (timeout),
        .iter_count  (iter_count)
    );

    typedef struct {
        bit     to;
        int     iter;
        longint t_rise;
        int     hold;
    } exp_t;

    exp_t sb[$];
    int   nvec;
    int   nerr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act,
                         input longint req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {ldX, ldTmp, selTmp, ready, busy, result_valid, timeout};
    endfunction

    // One run: the winner appears at CHECK number k (k > MI never wins),
    // ack comes d cycles after the result shows, start optionally held.
    task automatic run(input int k, input int d, input bit hold);
        exp_t   e;
        int     n;
        int     mf;
        int     j;
        bit     to;
        longint t0;
        to = (k > MI);
        n  = to ? MI : k;
        mf = n * P + 2;
        t0 = $time;
        start = 1'b1;
        e.to     = to;
        e.iter   = n;
        e.t_rise = t0 + 10 * (2 + n * P);
        e.hold   = d + 1;
        sb.push_back(e);
        for (int m = 1; m <= mf + d; m++) begin
            @(negedge clk);
            start = hold;
            j = (m - 1) / P;
            if (m > 1 && (m - 1) % P == 0 && j <= n)
                dp_done = (j == k);
            else
                dp_done = 1'($urandom_range(0, 1));
            if (m == mf + d)
                ack = 1'b1;
            else if (m < mf)
                ack = 1'($urandom_range(0, 1));
            else
                ack = 1'b0;
        end
        @(negedge clk);
        ack     = 1'b0;
        dp_done = 1'b0;
        start   = 1'b0;
    endtask

    task automatic mid_reset();
        start = 1'b1;
        for (int m = 1; m <= P + 2; m++) begin
            @(negedge clk);
            start   = 1'b0;
            dp_done = 1'b0;
            ack     = 1'($urandom_range(0, 1));
        end
        check("pre_reset_iter", iter_count, 1);
        check("pre_reset_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outs", outs(), 7'b0001000);
        check("async_reset_iter", iter_count, 0);
        @(negedge clk);
        rst = 1'b0;
        ack = 1'b0;
    endtask

    // Monitor: collects pulse counts per run and scores each result
    // when its valid/timeout indication drops back to IDLE.
    initial begin
        int     nld;
        int     ntmp;
        int     nupd;
        int     hold;
        bit     active;
        bit     cur_to;
        longint trise;
        exp_t   e;
        nld = 0; ntmp = 0; nupd = 0; hold = 0;
        active = 0; cur_to = 0; trise = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                nld = 0; ntmp = 0; nupd = 0; active = 0;
            end else begin
                if (ldX) nld++;
                if (ldTmp) ntmp++;
                if (ldTmp && selTmp) nupd++;
                if ((result_valid || timeout) && !active) begin
                    active = 1;
                    trise  = $time;
                    hold   = 0;
                    cur_to = timeout;
                end
                if (active && (result_valid || timeout)) begin
                    hold++;
                end else if (active) begin
                    active = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("kind_timeout", cur_to, e.to);
                        check("iter_count", iter_count, e.iter);
                        check("result_time", trise, e.t_rise);
                        check("hold_cycles", hold, e.hold);
                        check("ldX_pulses", nld, 1);
                        check("update_pulses", nupd, e.iter);
                        check("ldTmp_pulses", ntmp, e.iter + 1);
                        check("ready_after_ack", ready, 1);
                    end
                    nld = 0; ntmp = 0; nupd = 0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        nvec = 0;
        nerr = 0;
        rst = 1'b1; start = 1'b0; dp_done = 1'b0; ack = 1'b0;
        #12;
        check("reset_outs", outs(), 7'b0001000);
        check("reset_iter", iter_count, 0);
        @(negedge clk);
        rst = 1'b0;
        run(1, 2, 1'b0);
        run(3, 0, 1'b0);
        run(9, 1, 1'b0);
        run(MI, 0, 1'b0);
        run(2, 0, 1'b1);
        run(1, 1, 1'b1);
        repeat (2) @(negedge clk);
        mid_reset();
        run(2, 1, 1'b0);
        repeat (40) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                dp_done = 1'($urandom_range(0, 1));
                ack     = 1'($urandom_range(0, 1));
            end
            dp_done = 1'b0;
            ack     = 1'b0;
            run($urandom_range(1, 6), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
        end
        repeat (10) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check("missing_result", 0, 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/maxnet_controller.md
MAXNET_CONTROLLER -- requirements
Module: maxnet_controller

Interface
REQ-001 SHALL have parameter PU_LATENCY, default 2, meaning clock cycles from a tmp-register load until ProcessingUnit results are valid (legal range 1..15).
REQ-002 SHALL have parameter MAX_ITER, default 64, meaning the maximum number of competition updates before a timeout is declared (legal range 1..255).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, run request; sampled only in IDLE.
REQ-006 SHALL have port dp_done, input, 1, the datapath's single-winner flag.
REQ-007 SHALL have port ack, input, 1, consumer acknowledge of result_valid or timeout.
REQ-008 SHALL have port ldX, output, 1, load pulse for the datapath input-capture registers.
REQ-009 SHALL have port ldTmp, output, 1, load pulse for the datapath working registers.
REQ-010 SHALL have port selTmp, output, 1, working-register source select: 0 = memory data, 1 = ReLU feedback.
REQ-011 SHALL have port ready, output, 1, high only in IDLE.
REQ-012 SHALL have port busy, output, 1, high in LOAD, WAIT_PU, UPDATE and CHECK.
REQ-013 SHALL have port result_valid, output, 1, high in FINISH while maxnumber is valid.
REQ-014 SHALL have port timeout, output, 1, high in ERROR.
REQ-015 SHALL have port iter_count, output, 8, the number of UPDATE cycles completed in the current or last run.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, LOAD, WAIT_PU, UPDATE, CHECK, FINISH and ERROR; all outputs SHALL be registered or decoded from state only.
REQ-017 IDLE: ldX=ldTmp=selTmp=0; start=1 SHALL go to LOAD next cycle and clear iter_count to 0; start=0 SHALL hold IDLE.
REQ-018 LOAD (1 cycle): ldX=1, ldTmp=1, selTmp=0; SHALL go to WAIT_PU with the latency counter cleared.
REQ-019 WAIT_PU: all load outputs 0; SHALL stay exactly PU_LATENCY cycles, then go to UPDATE.
REQ-020 UPDATE (1 cycle): ldTmp=1, selTmp=1, ldX=0; SHALL increment iter_count (saturating at 255) and go to CHECK.
REQ-021 CHECK (1 cycle): loads 0; dp_done=1 SHALL go to FINISH (dp_done takes priority); otherwise iter_count==MAX_ITER SHALL go to ERROR; otherwise SHALL go to WAIT_PU with the latency counter cleared.
REQ-022 FINISH: result_valid=1 held until ack=1, then IDLE; ack and start in the same cycle SHALL NOT start a new run (start is re-sampled in IDLE).
REQ-023 ERROR: timeout=1 held until ack=1, then IDLE.
REQ-024 start asserted outside IDLE SHALL be ignored, with no queuing; ack outside FINISH/ERROR SHALL be ignored.
REQ-025 dp_done SHALL be ignored in every state except CHECK.
REQ-026 ldX SHALL pulse exactly once per run; ldTmp SHALL pulse once in LOAD plus once per UPDATE.
REQ-027 The latency counter SHALL be 4 bits wide; iter_count SHALL be 8 bits wide and SHALL hold its value through FINISH, ERROR and IDLE until the next LOAD.
REQ-028 Run length to result_valid: 1 (LOAD) + N*(PU_LATENCY+2) cycles for N updates.

Reset
REQ-029 rst=1 SHALL, asynchronously and in any state including mid-run, force state IDLE, set the latency counter and iter_count to 0, and drive ldX=ldTmp=selTmp=busy=result_valid=timeout=0 and ready=1.
REQ-030 After rst deasserts, the first start SHALL be sampled on the next rising edge in IDLE.

Verification
REQ-031 Defaults, start pulse, dp_done=1 at the first CHECK -> LOAD at cycle 1, UPDATE at cycle 4, FINISH at cycle 6, iter_count=1, result_valid held until ack, then ready=1.
REQ-032 dp_done rising only at the 3rd CHECK -> exactly 3 UPDATE pulses with selTmp=1, iter_count=3, and ldX pulsed once.
REQ-033 MAX_ITER=4, dp_done held 0 -> ERROR after 4 updates, timeout=1 until ack, iter_count=4, result_valid never asserted.
REQ-034 dp_done=1 during WAIT_PU and UPDATE but 0 in CHECK -> no early FINISH; the loop continues.
REQ-035 rst pulsed mid-WAIT_PU of the 2nd iteration -> all outputs at reset values immediately, before the clock edge; a new start runs normally from iter_count=0.
REQ-036 start held high through a run, and ack+start in the same FINISH cycle -> no restart during the run; IDLE for one cycle, then LOAD.
